// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one data-memory port between the instruction
// fetch unit and the ALU load/store path.
//  clk, nRst                   clock, async active-low reset
//  MemIO/ALUAddr/ALUWrData     ALU request (01 read, 10 write, 00/11 none)
//  ValidMemData/ALURdData      ALU read response, held until MemIO leaves 01
//  FetchReq/FetchAddr          fetch read request (level)
//  FetchValid/FetchData        fetch response, single-cycle pulse
//  MemAddr/MemWrData/MemRe/MemWe/MemRdData  memory port, fixed read latency
//  Busy                        FSM is outside IDLE
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [1:0]        MemIO,
  input  logic [ADDR_W-1:0] ALUAddr,
  input  logic [DATA_W-1:0] ALUWrData,
  output logic              ValidMemData,
  output logic [DATA_W-1:0] ALURdData,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic              FetchValid,
  output logic [DATA_W-1:0] FetchData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              MemRe,
  output logic              MemWe,
  input  logic [DATA_W-1:0] MemRdData,
  output logic              Busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
    $error("mem_bus_arbiter: MEM_LAT must lie in 1..15");
  end

  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, ALU_RESP, FETCH_RESP} state_t;

  state_t            state, nxt;
  logic [SW-1:0]     starve_cnt;
  logic [3:0]        lat_cnt;
  logic              alu_armed, fetch_armed;
  logic              owner_fetch, abandon;
  logic [DATA_W-1:0] rd_q;

  logic alu_rd, alu_wr, alu_req, fetch_req, starved;
  logic grant_fetch, grant_alu, alu_drop;

  assign alu_rd      = (MemIO == 2'b01);
  assign alu_wr      = (MemIO == 2'b10);
  // Armed flags make each request level count once: a held MemIO/FetchReq
  // must go idle before it can be granted again.
  assign alu_req     = (alu_rd | alu_wr) & alu_armed;
  assign fetch_req   = FetchReq & fetch_armed;
  assign starved     = (starve_cnt == SW'(MAX_STARVE));
  assign grant_fetch = (state == IDLE) && fetch_req && (!alu_req || starved);
  assign grant_alu   = (state == IDLE) && alu_req && !grant_fetch;
  // An ALU read whose requester walked away before completion is dropped.
  assign alu_drop    = abandon | !alu_rd;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_fetch)    nxt = RD_ISSUE;
        else if (grant_alu) nxt = alu_wr ? WR : RD_ISSUE;
      end
      WR:       nxt = IDLE;
      RD_ISSUE: nxt = RD_WAIT;
      RD_WAIT: begin
        if (lat_cnt == 4'd0) begin
          if (owner_fetch)   nxt = FETCH_RESP;
          else if (alu_drop) nxt = IDLE;
          else               nxt = ALU_RESP;
        end
      end
      ALU_RESP:   if (!alu_rd) nxt = IDLE;
      FETCH_RESP: nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      lat_cnt     <= '0;
      alu_armed   <= 1'b1;
      fetch_armed <= 1'b1;
      owner_fetch <= 1'b0;
      abandon     <= 1'b0;
      rd_q        <= '0;
      MemAddr     <= '0;
      MemWrData   <= '0;
      MemRe       <= 1'b0;
      MemWe       <= 1'b0;
    end else begin
      state <= nxt;

      // Memory strobes live only in the single cycle after the grant.
      MemRe     <= (state == IDLE) && (nxt == RD_ISSUE);
      MemWe     <= (nxt == WR);
      MemAddr   <= grant_fetch ? FetchAddr : (grant_alu ? ALUAddr : '0);
      MemWrData <= (grant_alu && alu_wr) ? ALUWrData : '0;

      if (grant_fetch || grant_alu) begin
        owner_fetch <= grant_fetch;
        abandon     <= 1'b0;
        lat_cnt     <= 4'(MEM_LAT - 1);
      end else begin
        if ((state == RD_ISSUE || state == RD_WAIT) && !owner_fetch && !alu_rd)
          abandon <= 1'b1;
        if (state == RD_WAIT && lat_cnt != 4'd0)
          lat_cnt <= lat_cnt - 4'd1;
      end

      if (state == RD_WAIT && lat_cnt == 4'd0) rd_q <= MemRdData;

      if (grant_alu)                            alu_armed <= 1'b0;
      else if (MemIO == 2'b00 || MemIO == 2'b11) alu_armed <= 1'b1;

      if (!FetchReq)                 fetch_armed <= 1'b1;
      else if (state == FETCH_RESP)  fetch_armed <= 1'b0;

      // Counts arbitrations a qualified fetch lost to the ALU.
      if (!FetchReq || grant_fetch)
        starve_cnt <= '0;
      else if (fetch_req && grant_alu && !starved)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign Busy         = (state != IDLE);
  assign ValidMemData = (state == ALU_RESP);
  assign ALURdData    = ValidMemData ? rd_q : '0;
  assign FetchValid   = (state == FETCH_RESP);
  assign FetchData    = FetchValid ? rd_q : '0;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-memory port between the CPU instruction-fetch unit and the ALU's load/store path (the MemIO/ALUAddr/DataIO requests issued by PUSH/POP/LD/ST/STI/JPR).
- Sequences each access with a fixed-latency read FSM and generates ValidMemData back to the ALU.
- Fixed ALU priority, bounded by a fetch starvation guard.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from MemRe strobe to valid MemRdData; legal range 1..15.
- MAX_STARVE, 4, consecutive lost arbitrations after which a pending fetch wins over the ALU.

Ports:
- clk  in  1  system clock, all state on rising edge.
- nRst  in  1  asynchronous active-low reset.
- MemIO  in  2  ALU request: 00 NOP, 01 read, 10 write, 11 register write-back (ignored, treated as NOP).
- ALUAddr  in  ADDR_W  ALU access address.
- ALUWrData  in  DATA_W  ALU write data.
- ValidMemData  out  1  ALU read data valid.
- ALURdData  out  DATA_W  ALU read data.
- FetchReq  in  1  fetch read request, level.
- FetchAddr  in  ADDR_W  fetch address.
- FetchValid  out  1  fetch data valid, one-cycle pulse.
- FetchData  out  DATA_W  fetch read data.
- MemAddr  out  ADDR_W  memory address.
- MemWrData  out  DATA_W  memory write data.
- MemRe  out  1  memory read strobe.
- MemWe  out  1  memory write strobe.
- MemRdData  in  DATA_W  memory read data, valid MEM_LAT cycles after MemRe.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (nRst=0, asynchronous): all outputs 0, state IDLE, StarveCnt=0, AluArmed=1, FetchArmed=1. Deasserting nRst mid-access aborts it with no response.
- Request qualification:
  - ALU request = (MemIO==01 or 10) and AluArmed.
  - AluArmed clears when an ALU request is granted and sets again once MemIO==00 or 11 is sampled.
  - Fetch request = FetchReq and FetchArmed. FetchArmed clears when FetchValid fires and sets again when FetchReq is sampled low.
- Arbitration in IDLE, decided in one cycle:
  - Both requesting: ALU wins unless StarveCnt==MAX_STARVE, in which case fetch wins.
  - StarveCnt increments, saturating, on each cycle fetch loses. It clears on a fetch grant or whenever FetchReq=0.
- States:
  - IDLE -> WR (ALU write), RD_ISSUE (any read), or stay.
  - WR: MemWe=1, MemAddr=ALUAddr, MemWrData=ALUWrData for exactly 1 cycle, then IDLE. No ValidMemData for writes.
  - RD_ISSUE: MemRe=1 for 1 cycle, MemAddr = the granted address, latched at grant. Owner (ALU or fetch) latched. Latency counter loaded with MEM_LAT-1. Next state RD_WAIT.
  - RD_WAIT: counter decrements each cycle. At 0, MemRdData is captured that same edge; next state is ALU_RESP or FETCH_RESP.
  - ALU_RESP: ValidMemData=1, ALURdData=captured data, held until MemIO!=01 is sampled, then both go to 0 and the state returns to IDLE.
  - FETCH_RESP: FetchValid=1 and FetchData for exactly 1 cycle, then IDLE.
- Latency:
  - Read, grant to valid = MEM_LAT+2 cycles; a back-to-back request is granted the cycle after return to IDLE.
  - Write occupies 2 cycles including IDLE.
- Abandoned ALU read: if MemIO leaves 01 during RD_ISSUE or RD_WAIT, the read still completes on the memory side. The result is discarded, ValidMemData stays 0, and the state goes straight to IDLE.
- MemAddr, MemWrData, MemRe and MemWe are registered outputs, held at 0 outside RD_ISSUE/WR. The data outputs ALURdData and FetchData stay valid only while their valid flag is high, 0 otherwise.
- MEM_LAT outside 1..15 is illegal; the design halts elaboration via a generate-time check.

Test Plan:
- ALU read, MEM_LAT=2: MemIO=01, ALUAddr=0x100, memory returns 0xDEADBEEF -> MemRe pulse at cycle 1, ValidMemData=1 at cycle 4 with ALURdData=0xDEADBEEF, held until MemIO=00, then cleared next edge.
- ALU write: MemIO=10, ALUAddr=0x20, ALUWrData=0x55 held for 3 cycles -> exactly one MemWe pulse with 0x20/0x55. A second pulse appears only after MemIO goes 00 then 10 again.
- Contention and starvation, MAX_STARVE=4: FetchReq held high while the ALU issues 6 back-to-back reads (toggling MemIO through 00) -> ALU wins 4 arbitrations, the 5th grant goes to fetch (FetchValid pulse), then ALU resumes and StarveCnt is 0 after the fetch grant.
- Abandoned read: MemIO=01 then 00 during RD_WAIT -> ValidMemData never asserts, Busy drops MEM_LAT+2 cycles after grant, and the next fetch is served normally.
- Async reset mid-read: nRst=0 during RD_WAIT -> MemRe/MemWe/ValidMemData/FetchValid/Busy go 0 immediately with no clock edge. After release, FetchReq=1 with FetchAddr=0x40 is served with the normal MEM_LAT+2 latency.
- MEM_LAT=1 sweep: fetch read of 0x0 returning 0x12345678 -> FetchValid pulses exactly 3 cycles after grant with FetchData=0x12345678, width 1 cycle.
